pc_fetch_reg: RTL and testbench
===============================

PC_FETCH_REG -- requirements
Module: pc_fetch_reg

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 npc  in  32  next PC from the downstream next-PC select; sampled only on fetch handoff.
REQ-004 seq_pc  out  32  pc+4, combinational, fed to the next-PC select as its sequential input.
REQ-005 ex_flush  in  1  exception/eret redirect pulse; ex_target  in  32  redirect address.
REQ-006 inst_req  out  1; inst_addr  out  32; inst_addr_ok  in  1; inst_data_ok  in  1; inst_rdata  in  32  SRAM-like instruction port.
REQ-007 id_allowin  in  1  decode stage accepts instruction this cycle.
REQ-008 fs_valid  out  1; fs_pc  out  32; fs_inst  out  32  fetched instruction to decode.
REQ-009 pc  out  32  current fetch PC.

Function
REQ-010 FSM states SHALL be REQ, WAIT and HOLD; the state after reset SHALL be REQ.
REQ-011 REQ: inst_req=1, inst_addr=pc, both held stable until inst_addr_ok=1, then go to WAIT.
REQ-012 WAIT: inst_req=0; on inst_data_ok with no cancel pending, fs_inst<=inst_rdata, fs_pc<=pc, fs_valid<=1, go to HOLD.
REQ-013 HOLD: fs_valid=1, fs_inst/fs_pc stable; on id_allowin, pc<=npc, fs_valid<=0, go to REQ (one-cycle handoff bubble).
REQ-014 Minimum latency REQ->fs_valid SHALL be 2 cycles (addr_ok in cycle 0, data_ok in cycle 1, fs_valid high in cycle 2).
REQ-015 seq_pc SHALL be pc+32'd4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-016 ex_flush in REQ with inst_addr_ok=0: latch ex_target into the redirect buffer; on the later addr_ok, go to WAIT with cancel set.
REQ-017 ex_flush in REQ with inst_addr_ok=1 same cycle: go to WAIT with cancel set and the buffer loaded.
REQ-018 ex_flush in WAIT (including the same cycle as data_ok): set cancel and latch the target.
REQ-019 In WAIT with cancel set, data_ok SHALL discard inst_rdata, set pc<=buffered target, clear cancel and the buffer, and go to REQ.
REQ-020 ex_flush in HOLD SHALL win over id_allowin: fs_valid<=0, pc<=ex_target, go to REQ; npc is ignored.
REQ-021 A second ex_flush while the buffer is full SHALL overwrite the target (the latest wins).
REQ-022 fs_valid SHALL never be high for a cancelled fetch.

Reset
REQ-023 On rst: pc=0xBFC00000, state=REQ, fs_valid=0, fs_pc=0, fs_inst=0, cancel=0, buffer empty, inst_req=0 while rst is high.
REQ-024 rst mid-transaction SHALL abandon the outstanding request; the first data_ok after reset with no request issued SHALL be ignored.

Configuration
REQ-025 Macro PC_ALIGN_CHECK_EN compiles in output fs_adel (1 bit).
REQ-026 With the macro: if pc[1:0]!=0 in REQ, no inst_req is issued, HOLD is entered next cycle with fs_adel=1, fs_inst=0, fs_pc=pc.
REQ-027 Without the macro: no fs_adel port, pc[1:0] is not checked, and the fetch proceeds normally.

Structure
REQ-028 The shared cpu package SHALL hold RESET_VEC=0xBFC00000, EX_VEC=0xBFC00380 and the FSM state enum.
REQ-029 One sub-module, pc_redirect_buf, SHALL hold the cancel flag and the buffered target (set/overwrite/clear).

Verification
REQ-030 Release rst, addr_ok and data_ok immediate, rdata=0x24010001 -> inst_addr=0xBFC00000, fs_valid in cycle 2, fs_inst=0x24010001.
REQ-031 HOLD with id_allowin=0 for 5 cycles -> fs_valid/fs_inst stable, no inst_req; then id_allowin=1, npc=0xBFC00010 -> next inst_addr=0xBFC00010.
REQ-032 ex_flush, ex_target=0xBFC00380 during WAIT, data_ok 3 cycles later -> rdata discarded, fs_valid stays 0, next inst_addr=0xBFC00380.
REQ-033 ex_flush and id_allowin same cycle in HOLD, npc=0x1000 -> next inst_addr=ex_target, not 0x1000.
REQ-034 ex_flush while inst_addr_ok=0 for 4 cycles -> inst_addr unchanged until addr_ok, then cancel, then refetch at ex_target.
REQ-035 With PC_ALIGN_CHECK_EN, npc=0xBFC00002 -> no inst_req, fs_adel=1, fs_pc=0xBFC00002.

Source files
------------

// File: rtl/pc_fetch_reg_pkg.sv
// Shared fetch-side definitions: reset/exception vectors and the fetch FSM state type.
package pc_fetch_reg_pkg;

  localparam logic [31:0] RESET_VEC  = 32'hBFC0_0000;
  localparam logic [31:0] EX_VEC     = 32'hBFC0_0380;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Redirect buffer: remembers a pending exception target and whether the in-flight fetch is cancelled.
module pc_redirect_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        arm_i,
  input  logic        clear_i,
  output logic        cancel_o,
  output logic        full_o,
  output logic [31:0] target_o
);

  logic        cancel_q, cancel_d;
  logic        full_q, full_d;
  logic [31:0] target_q, target_d;

  always_comb begin
    cancel_d = cancel_q;
    full_d   = full_q;
    target_d = target_q;
    if (clear_i) begin
      cancel_d = 1'b0;
      full_d   = 1'b0;
      target_d = '0;
    end else begin
      // A newer redirect always overwrites an older one.
      if (load_i) begin
        full_d   = 1'b1;
        target_d = target_i;
      end
      if (arm_i) begin
        cancel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cancel_q <= 1'b0;
      full_q   <= 1'b0;
      target_q <= '0;
    end else begin
      cancel_q <= cancel_d;
      full_q   <= full_d;
      target_q <= target_d;
    end
  end

  assign cancel_o = cancel_q;
  assign full_o   = full_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_fetch_reg.sv
// Fetch-stage PC register and REQ/WAIT/HOLD instruction-port FSM with exception redirect.
// Optional PC_ALIGN_CHECK_EN adds fs_adel for misaligned fetch PCs.
module pc_fetch_reg
  import pc_fetch_reg_pkg::*;
(
`ifdef PC_ALIGN_CHECK_EN
  output logic        fs_adel,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] seq_pc,
  input  logic        ex_flush,
  input  logic [31:0] ex_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic [31:0] pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fs_valid_q, fs_valid_d;
  logic [31:0]  fs_pc_q, fs_pc_d;
  logic [31:0]  fs_inst_q, fs_inst_d;
  logic         misaligned;

  logic        buf_load, buf_arm, buf_clear;
  logic        buf_cancel, buf_full;
  logic [31:0] buf_target;

`ifdef PC_ALIGN_CHECK_EN
  logic fs_adel_q, fs_adel_d;
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  pc_redirect_buf u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (buf_load),
    .target_i (ex_target),
    .arm_i    (buf_arm),
    .clear_i  (buf_clear),
    .cancel_o (buf_cancel),
    .full_o   (buf_full),
    .target_o (buf_target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;
    buf_load   = 1'b0;
    buf_arm    = 1'b0;
    buf_clear  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    fs_adel_d  = fs_adel_q;
`endif
    unique case (state_q)
      StReq: begin
        if (misaligned) begin
          if (ex_flush) begin
            pc_d = ex_target;
          end else begin
            state_d    = StHold;
            fs_valid_d = 1'b1;
            fs_pc_d    = pc_q;
            fs_inst_d  = '0;
`ifdef PC_ALIGN_CHECK_EN
            fs_adel_d  = 1'b1;
`endif
          end
        end else if (inst_addr_ok) begin
          state_d  = StWait;
          buf_load = ex_flush;
          buf_arm  = ex_flush || buf_full;
        end else begin
          // Address is still pending, so it must stay stable; only remember the target.
          buf_load = ex_flush;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          if (buf_cancel || ex_flush) begin
            state_d   = StReq;
            pc_d      = ex_flush ? ex_target : buf_target;
            buf_clear = 1'b1;
          end else begin
            state_d    = StHold;
            fs_valid_d = 1'b1;
            fs_pc_d    = pc_q;
            fs_inst_d  = inst_rdata;
          end
        end else if (ex_flush) begin
          buf_load = 1'b1;
          buf_arm  = 1'b1;
        end
      end
      StHold: begin
        if (ex_flush || id_allowin) begin
          state_d    = StReq;
          fs_valid_d = 1'b0;
          pc_d       = ex_flush ? ex_target : npc;
`ifdef PC_ALIGN_CHECK_EN
          fs_adel_d  = 1'b0;
`endif
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_VEC;
      fs_valid_q <= 1'b0;
      fs_pc_q    <= '0;
      fs_inst_q  <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fs_adel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
`ifdef PC_ALIGN_CHECK_EN
      fs_adel_q  <= fs_adel_d;
`endif
    end
  end

  assign inst_req  = !rst && (state_q == StReq) && !misaligned;
  assign inst_addr = pc_q;
  assign seq_pc    = pc_q + INST_BYTES;
  assign pc        = pc_q;
  assign fs_valid  = fs_valid_q;
  assign fs_pc     = fs_pc_q;
  assign fs_inst   = fs_inst_q;
`ifdef PC_ALIGN_CHECK_EN
  assign fs_adel   = fs_adel_q;
`endif

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Directed self-checking bench for pc_fetch_reg (default build; align checks if PC_ALIGN_CHECK_EN).
module tb_pc_fetch_reg;
  import pc_fetch_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc, seq_pc, ex_target, inst_addr, inst_rdata, fs_pc, fs_inst, pc;
  logic        ex_flush, inst_req, inst_addr_ok, inst_data_ok, id_allowin, fs_valid;
  int          checks = 0;
  int          failures = 0;
`ifdef PC_ALIGN_CHECK_EN
  logic        fs_adel;
`endif

  pc_fetch_reg dut (
`ifdef PC_ALIGN_CHECK_EN
    .fs_adel      (fs_adel),
`endif
    .clk          (clk),
    .rst          (rst),
    .npc          (npc),
    .seq_pc       (seq_pc),
    .ex_flush     (ex_flush),
    .ex_target    (ex_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_allowin   (id_allowin),
    .fs_valid     (fs_valid),
    .fs_pc        (fs_pc),
    .fs_inst      (fs_inst),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one clean fetch from REQ to HOLD with immediate handshakes.
  task automatic fetch(input logic [31:0] rdata);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = rdata;
    tick();
    inst_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (inst_req !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b exp=0", inst_req);
    end
    checks++;
    if (pc !== 32'hBFC00000) begin
      failures++; $display("FAIL reset_pc got=%h exp=bfc00000", pc);
    end
    checks++;
    if ({fs_valid, fs_pc, fs_inst} !== 65'd0) begin
      failures++; $display("FAIL reset_fs got=%b/%h/%h exp=0/0/0", fs_valid, fs_pc, fs_inst);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000 || seq_pc !== 32'hBFC00004) begin
      failures++;
      $display("FAIL reset_release got=%b/%h/%h exp=1/bfc00000/bfc00004",
               inst_req, inst_addr, seq_pc);
    end
  endtask

  task automatic test_basic_fetch();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    checks++;
    if (inst_req !== 1'b0 || fs_valid !== 1'b0) begin
      failures++; $display("FAIL basic_wait got=%b/%b exp=0/0", inst_req, fs_valid);
    end
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h24010001;
    tick();
    inst_data_ok = 1'b0;
    checks++;
    if (fs_valid !== 1'b1 || fs_inst !== 32'h24010001 || fs_pc !== 32'hBFC00000) begin
      failures++;
      $display("FAIL basic_hold got=%b/%h/%h exp=1/24010001/bfc00000", fs_valid, fs_inst, fs_pc);
    end
  endtask

  task automatic test_hold_stall();
    id_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fs_valid !== 1'b1 || fs_inst !== 32'h24010001 || inst_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_stall[%0d] got=%b/%h/%b exp=1/24010001/0", i, fs_valid, fs_inst,
                 inst_req);
      end
    end
    id_allowin = 1'b1;
    npc        = 32'hBFC00010;
    tick();
    id_allowin = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00010) begin
      failures++;
      $display("FAIL hold_handoff got=%b/%b/%h exp=0/1/bfc00010", fs_valid, inst_req, inst_addr);
    end
    checks++;
    if (seq_pc !== 32'hBFC00014) begin
      failures++; $display("FAIL hold_seq_pc got=%h exp=bfc00014", seq_pc);
    end
  endtask

  task automatic test_flush_wait();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    ex_flush     = 1'b1;
    ex_target    = EX_VEC;
    tick();
    ex_flush = 1'b0;
    tick();
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEADBEEF;
    tick();
    inst_data_ok = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00380) begin
      failures++;
      $display("FAIL flush_wait got=%b/%b/%h exp=0/1/bfc00380", fs_valid, inst_req, inst_addr);
    end
    fetch(32'h11112222);
    checks++;
    if (fs_valid !== 1'b1 || fs_inst !== 32'h11112222 || fs_pc !== 32'hBFC00380) begin
      failures++;
      $display("FAIL flush_refetch got=%b/%h/%h exp=1/11112222/bfc00380", fs_valid, fs_inst,
               fs_pc);
    end
  endtask

  task automatic test_flush_vs_allowin();
    ex_flush   = 1'b1;
    ex_target  = 32'h80000000;
    id_allowin = 1'b1;
    npc        = 32'h00001000;
    tick();
    ex_flush   = 1'b0;
    id_allowin = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_addr !== 32'h80000000) begin
      failures++; $display("FAIL flush_vs_allowin got=%b/%h exp=0/80000000", fs_valid, inst_addr);
    end
  endtask

  task automatic test_flush_addr_stall();
    for (int i = 0; i < 4; i++) begin
      ex_flush  = (i == 0) || (i == 2);
      ex_target = (i == 0) ? 32'h12340000 : 32'hBFC00380;
      tick();
      ex_flush = 1'b0;
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h80000000) begin
        failures++;
        $display("FAIL addr_stall[%0d] got=%b/%h exp=1/80000000", i, inst_req, inst_addr);
      end
    end
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hCAFEF00D;
    tick();
    inst_data_ok = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00380) begin
      failures++;
      $display("FAIL addr_stall_refetch got=%b/%b/%h exp=0/1/bfc00380", fs_valid, inst_req,
               inst_addr);
    end
  endtask

  task automatic test_flush_same_addr_ok();
    inst_addr_ok = 1'b1;
    ex_flush     = 1'b1;
    ex_target    = 32'h00000100;
    tick();
    inst_addr_ok = 1'b0;
    ex_flush     = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h0BADF00D;
    tick();
    inst_data_ok = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_addr !== 32'h00000100) begin
      failures++; $display("FAIL flush_addr_ok got=%b/%h exp=0/00000100", fs_valid, inst_addr);
    end
  endtask

  task automatic test_seq_wrap();
    fetch(32'h00000000);
    id_allowin = 1'b1;
    npc        = 32'hFFFFFFFC;
    tick();
    id_allowin = 1'b0;
    checks++;
    if (inst_addr !== 32'hFFFFFFFC || seq_pc !== 32'h00000000) begin
      failures++; $display("FAIL seq_wrap got=%h/%h exp=fffffffc/00000000", inst_addr, seq_pc);
    end
  endtask

  task automatic test_flush_on_data_ok();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    ex_flush     = 1'b1;
    ex_target    = 32'h00000200;
    tick();
    inst_data_ok = 1'b0;
    ex_flush     = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h00000200) begin
      failures++;
      $display("FAIL flush_data_ok got=%b/%b/%h exp=0/1/00000200", fs_valid, inst_req, inst_addr);
    end
  endtask

  task automatic test_reset_mid();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (inst_req !== 1'b0 || pc !== 32'hBFC00000 || fs_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b/%h/%b exp=0/bfc00000/0", inst_req, pc, fs_valid);
    end
    rst          = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h55555555;
    tick();
    inst_data_ok = 1'b0;
    checks++;
    if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin
      failures++;
      $display("FAIL stale_data_ok got=%b/%b/%h exp=0/1/bfc00000", fs_valid, inst_req, inst_addr);
    end
  endtask

  task automatic test_align();
    fetch(32'h00000001);
    id_allowin = 1'b1;
    npc        = 32'hBFC00002;
    tick();
    id_allowin = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (inst_req !== 1'b0) begin
      failures++; $display("FAIL align_no_req got=%b exp=0", inst_req);
    end
    tick();
    checks++;
    if (fs_valid !== 1'b1 || fs_adel !== 1'b1 || fs_pc !== 32'hBFC00002 || fs_inst !== 32'd0) begin
      failures++;
      $display("FAIL align_adel got=%b/%b/%h/%h exp=1/1/bfc00002/0", fs_valid, fs_adel, fs_pc,
               fs_inst);
    end
`else
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00002) begin
      failures++; $display("FAIL align_off_req got=%b/%h exp=1/bfc00002", inst_req, inst_addr);
    end
    fetch(32'h77778888);
    checks++;
    if (fs_valid !== 1'b1 || fs_pc !== 32'hBFC00002 || fs_inst !== 32'h77778888) begin
      failures++;
      $display("FAIL align_off_fetch got=%b/%h/%h exp=1/bfc00002/77778888", fs_valid, fs_pc,
               fs_inst);
    end
`endif
  endtask

  initial begin
    rst          = 1'b1;
    npc          = '0;
    ex_flush     = 1'b0;
    ex_target    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    id_allowin   = 1'b0;
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_flush_wait();
    test_flush_vs_allowin();
    test_flush_addr_stall();
    test_flush_same_addr_ok();
    test_seq_wrap();
    test_flush_on_data_ok();
    test_reset_mid();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
